cache_line_controller: RTL and testbench
========================================

# cache_line_controller

Per-command L1 controller that sits directly upstream of the set-associative cache array. It accepts one trace command at a time and reads the addressed set from the array. It resolves hit/miss, picks a victim, applies MESI and LRU updates, and writes the whole set back. It also emits the L2/bus operation the command requires and maintains hit/miss statistics.

## Interface
- SETS, 16384, number of sets (power of two); set index width SI = log2(SETS)
- WAYS, 8, ways per set (power of two); LRU width LW = log2(WAYS)
- ADDR_W, 32, address width; byte offset fixed at 6 bits; tag width = ADDR_W-6-SI
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle, command accepted on valid&ready
- cmd  in  command_t  opcode n and address (tag / set_index / offset)
- set_index  out  SI  set currently addressed in the array
- rd_line  in  cache_line_t[WAYS]  set contents from array, valid the cycle after set_index changes
- wr_en  out  1  one-cycle write strobe for the addressed set
- wr_line  out  cache_line_t[WAYS]  updated set contents
- array_clear  out  1  one-cycle pulse requesting array reinitialisation (opcode 8)
- done  out  1  one-cycle completion pulse
- hit  out  1  qualified by done: tag match in a non-I way
- bus_op  out  3  qualified by done: 0 NONE, 1 READ, 2 WRITE, 3 RFO, 4 INVALIDATE
- evict_wb  out  1  qualified by done: Modified victim written back before fill
- reads, writes, hits, misses  out  32 each  statistics counters, saturating

## Operation
- FSM: IDLE -> LOOKUP -> UPDATE -> IDLE; no other states.
- IDLE: cmd_ready=1; on valid&ready, latch cmd and drive set_index = cmd.address.set_index.
- LOOKUP: register rd_line and compute the match way. A match is tag equal and MESI != I; more than one match is illegal, and the lowest way wins.
- UPDATE: drive wr_line and wr_en for opcodes 0-4, assert done, then return to IDLE.
- LRU encoding: 0 = MRU, WAYS-1 = LRU.
  - On touch of way w with old value v, ways with LRU < v increment, and way w becomes 0.
  - Invalidation leaves LRU unchanged.
- Victim selection: the lowest-index I way; if no way is I, the way with LRU == WAYS-1.
- Opcode 0 read / 2 ifetch:
  - Hit: MESI unchanged, bus NONE, reads+1, hits+1.
  - Miss: fill victim with the new tag, MESI = E, bus READ, reads+1, misses+1.
- Opcode 1 write:
  - Hit on M/E: M, bus NONE.
  - Hit on S: M, bus INVALIDATE.
  - Miss: fill, M, bus RFO.
  - Counters: writes+1; hits or misses +1.
- Victim fill: evict_wb=1 iff the victim was M.
- Opcode 3 (L2 invalidate): match in S -> I, bus NONE; otherwise no state change. No counters, no LRU touch.
- Opcode 4 (L2 data request):
  - Match in M: -> S, bus WRITE.
  - Match in E: -> S, bus NONE.
  - Otherwise unchanged.
  - No counters.
- Opcode 8: array_clear pulse, all counters to 0, wr_en=0, bus NONE.
- Opcode 9 and undefined opcodes: done only; wr_en=0, no state change.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - State IDLE, cmd_ready=1.
  - wr_en, array_clear, done, hit and evict_wb all 0; bus_op=0; set_index=0.
  - All counters 0.
- Latency: accept at cycle T. LOOKUP at T+1. wr_en/done/bus_op at T+2. cmd_ready=1 at T+3, so the next accept is at T+3 at the earliest.
- cmd_ready=0 in LOOKUP and UPDATE; cmd_valid there is ignored and not latched.
- set_index is held stable from T through T+2.
- wr_line holds the full set, including unmodified ways.
- Reset asserted in any state: next cycle IDLE, no wr_en/done issued. The in-flight command is dropped and counters are cleared.
- Opcode 8 counter clear takes effect in the UPDATE cycle and wins over a saturating increment.

## Test plan
- Reset, then read 0x0000_0040 to an empty set 1 -> miss, way 0 filled E, LRU way0=0, bus READ, done at T+2, misses=1.
- Repeat the same read -> hit=1, MESI E, bus NONE, hits=1, reads=2.
- Write to the same address, then an opcode 4 request -> first M with bus NONE; then S with bus WRITE.
- Nine distinct-tag reads to set 5, the first written -> 9th evicts way 0 (LRU==7), evict_wb=1, new line E.
- Opcode 3 on an S line then on an absent tag -> S->I; second leaves wr_line == rd_line.
- Reset at LOOKUP of a write; preload reads=32'hFFFF_FFFF then read -> no wr_en after reset; counter stays saturated.

Source files
------------

// File: rtl/cache_line_controller.sv
// ----------------------------------------------------------------------------
// cache_line_controller
// Per-command L1 controller in front of a set-associative tag/state array.
// Each accepted command reads one set, resolves hit/miss, chooses a victim,
// applies MESI and LRU updates, writes the whole set back and reports the
// L2/bus operation it needs, while keeping saturating hit/miss statistics.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd                    opcode + address (tag / set_index / offset)
//   set_index              set addressed in the array
//   rd_line                set contents, valid the cycle after set_index
//   wr_en / wr_line        one-cycle write of the updated set
//   array_clear            one-cycle request to reinitialise the array
//   done                   one-cycle completion pulse, qualifies the next three
//   hit, bus_op, evict_wb  lookup result, required bus op, dirty victim
//   reads/writes/hits/misses  saturating statistics counters
// ----------------------------------------------------------------------------
package cache_line_controller_pkg;
   localparam int SETS   = 16384;
   localparam int WAYS   = 8;
   localparam int ADDR_W = 32;
   localparam int OFF_W  = 6;
   localparam int SI     = $clog2(SETS);
   localparam int LW     = $clog2(WAYS);
   localparam int TAG_W  = ADDR_W - OFF_W - SI;

   typedef enum logic [1:0] {
      MESI_I = 2'd0,
      MESI_S = 2'd1,
      MESI_E = 2'd2,
      MESI_M = 2'd3
   } mesi_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [SI-1:0]    set_index;
      logic [OFF_W-1:0] offset;
   } address_t;

   typedef struct packed {
      logic [3:0] opcode;
      address_t   address;
   } command_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      mesi_t            mesi;
      logic [LW-1:0]    lru;
   } cache_line_t;

   typedef cache_line_t [WAYS-1:0] cache_set_t;

   localparam logic [2:0] BUS_NONE       = 3'd0;
   localparam logic [2:0] BUS_READ       = 3'd1;
   localparam logic [2:0] BUS_WRITE      = 3'd2;
   localparam logic [2:0] BUS_RFO        = 3'd3;
   localparam logic [2:0] BUS_INVALIDATE = 3'd4;
endpackage

module cache_line_controller
   import cache_line_controller_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  command_t               cmd,
   output logic [SI-1:0]          set_index,
   input  cache_line_t [WAYS-1:0] rd_line,
   output logic                   wr_en,
   output cache_line_t [WAYS-1:0] wr_line,
   output logic                   array_clear,
   output logic                   done,
   output logic                   hit,
   output logic [2:0]             bus_op,
   output logic                   evict_wb,
   output logic [31:0]            reads,
   output logic [31:0]            writes,
   output logic [31:0]            hits,
   output logic [31:0]            misses
);
   localparam logic [3:0] OP_READ   = 4'd0;
   localparam logic [3:0] OP_WRITE  = 4'd1;
   localparam logic [3:0] OP_IFETCH = 4'd2;
   localparam logic [3:0] OP_L2_INV = 4'd3;
   localparam logic [3:0] OP_L2_REQ = 4'd4;
   localparam logic [3:0] OP_CLEAR  = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_UPDATE = 2'd2
   } state_t;

   // Lowest-index set bit of a way vector (0 when empty).
   function automatic logic [LW-1:0] first_way(input logic [WAYS-1:0] v);
      logic [LW-1:0] w;
      w = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (v[i]) w = LW'(i);
         else      w = w;
      end
      return w;
   endfunction

   // Make way w the MRU: every way younger than w's old age ages by one.
   function automatic cache_set_t lru_touch(input cache_set_t s, input logic [LW-1:0] w);
      cache_set_t    r;
      logic [LW-1:0] v;
      r = s;
      v = s[w].lru;
      for (int i = 0; i < WAYS; i++) begin
         if (s[i].lru < v) r[i].lru = s[i].lru + LW'(1);
         else              r[i].lru = s[i].lru;
      end
      r[w].lru = '0;
      return r;
   endfunction

   function automatic cache_set_t fill_way(input cache_set_t s, input logic [LW-1:0] w,
                                           input logic [TAG_W-1:0] tag, input mesi_t mesi);
      cache_set_t r;
      r         = lru_touch(s, w);
      r[w].tag  = tag;
      r[w].mesi = mesi;
      return r;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
      if (en && (c != 32'hFFFF_FFFF)) return c + 32'd1;
      else                            return c;
   endfunction

   state_t        state_r, state_s;
   command_t      cmd_r;
   logic          accept_s;
   logic [WAYS-1:0] match_vec_s, free_vec_s, oldest_vec_s;
   logic          match_s;
   logic [LW-1:0] match_way_s, victim_way_s;
   cache_set_t    new_set_s;
   logic [2:0]    bus_s;
   logic          evict_s, wr_s, clr_s, hit_s;
   logic          inc_rd_s, inc_wr_s, inc_hit_s, inc_miss_s;
   logic          wr_en_r, done_r, hit_r, evict_wb_r, array_clear_r;
   logic [2:0]    bus_op_r;
   cache_set_t    wr_line_r;
   logic [31:0]   reads_r, writes_r, hits_r, misses_r;
   logic          offset_unused_s;

   assign offset_unused_s = ^cmd.address.offset;
   assign cmd_ready = (state_r == ST_IDLE);
   assign accept_s  = cmd_valid && cmd_ready;
   // The array sees the new set in the accept cycle, then the latched one.
   assign set_index = accept_s ? cmd.address.set_index : cmd_r.address.set_index;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_s;
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:   if (cmd_valid) state_s = ST_LOOKUP; else state_s = ST_IDLE;
         ST_LOOKUP: state_s = ST_UPDATE;
         ST_UPDATE: state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // Command latch; only loaded on a handshake so busy-time commands are ignored.
   always_ff @(posedge clk) begin
      if (reset)         cmd_r <= '0;
      else if (accept_s) cmd_r <= cmd;
      else               cmd_r <= cmd_r;
   end

   // Per-way match / free / oldest flags from the set read back.
   always_comb begin
      match_vec_s  = '0;
      free_vec_s   = '0;
      oldest_vec_s = '0;
      for (int i = 0; i < WAYS; i++) begin
         match_vec_s[i]  = (rd_line[i].mesi != MESI_I) && (rd_line[i].tag == cmd_r.address.tag);
         free_vec_s[i]   = (rd_line[i].mesi == MESI_I);
         oldest_vec_s[i] = (rd_line[i].lru == LW'(WAYS - 1));
      end
   end

   assign match_s      = |match_vec_s;
   assign match_way_s  = first_way(match_vec_s);
   assign victim_way_s = (|free_vec_s) ? first_way(free_vec_s) : first_way(oldest_vec_s);

   // Opcode decode: updated set, bus op and counter increments.
   always_comb begin
      new_set_s  = rd_line;
      bus_s      = BUS_NONE;
      evict_s    = 1'b0;
      wr_s       = 1'b0;
      clr_s      = 1'b0;
      hit_s      = 1'b0;
      inc_rd_s   = 1'b0;
      inc_wr_s   = 1'b0;
      inc_hit_s  = 1'b0;
      inc_miss_s = 1'b0;
      case (cmd_r.opcode)
         OP_READ, OP_IFETCH, OP_WRITE: begin
            wr_s       = 1'b1;
            hit_s      = match_s;
            inc_rd_s   = (cmd_r.opcode != OP_WRITE);
            inc_wr_s   = (cmd_r.opcode == OP_WRITE);
            inc_hit_s  = match_s;
            inc_miss_s = !match_s;
            if (match_s) begin
               new_set_s = lru_touch(rd_line, match_way_s);
               if (cmd_r.opcode == OP_WRITE) begin
                  new_set_s[match_way_s].mesi = MESI_M;
                  bus_s = (rd_line[match_way_s].mesi == MESI_S) ? BUS_INVALIDATE : BUS_NONE;
               end else begin
                  bus_s = BUS_NONE;
               end
            end else begin
               evict_s = (rd_line[victim_way_s].mesi == MESI_M);
               if (cmd_r.opcode == OP_WRITE) begin
                  new_set_s = fill_way(rd_line, victim_way_s, cmd_r.address.tag, MESI_M);
                  bus_s     = BUS_RFO;
               end else begin
                  new_set_s = fill_way(rd_line, victim_way_s, cmd_r.address.tag, MESI_E);
                  bus_s     = BUS_READ;
               end
            end
         end
         OP_L2_INV: begin
            wr_s  = 1'b1;
            hit_s = match_s;
            if (match_s && (rd_line[match_way_s].mesi == MESI_S)) new_set_s[match_way_s].mesi = MESI_I;
            else                                                   new_set_s = rd_line;
         end
         OP_L2_REQ: begin
            wr_s  = 1'b1;
            hit_s = match_s;
            if (match_s && (rd_line[match_way_s].mesi == MESI_M)) begin
               new_set_s[match_way_s].mesi = MESI_S;
               bus_s = BUS_WRITE;
            end else if (match_s && (rd_line[match_way_s].mesi == MESI_E)) begin
               new_set_s[match_way_s].mesi = MESI_S;
            end else begin
               new_set_s = rd_line;
            end
         end
         OP_CLEAR: clr_s = 1'b1;
         default:  clr_s = 1'b0;
      endcase
   end

   // Result registers: loaded at the end of LOOKUP, visible in UPDATE.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_r       <= 1'b0;
         done_r        <= 1'b0;
         hit_r         <= 1'b0;
         evict_wb_r    <= 1'b0;
         array_clear_r <= 1'b0;
         bus_op_r      <= BUS_NONE;
         wr_line_r     <= '0;
      end else if (state_r == ST_LOOKUP) begin
         wr_en_r       <= wr_s;
         done_r        <= 1'b1;
         hit_r         <= hit_s;
         evict_wb_r    <= evict_s;
         array_clear_r <= clr_s;
         bus_op_r      <= bus_s;
         wr_line_r     <= new_set_s;
      end else begin
         wr_en_r       <= 1'b0;
         done_r        <= 1'b0;
         hit_r         <= 1'b0;
         evict_wb_r    <= 1'b0;
         array_clear_r <= 1'b0;
         bus_op_r      <= BUS_NONE;
         wr_line_r     <= wr_line_r;
      end
   end

   // Statistics; a clear command wins over any increment.
   always_ff @(posedge clk) begin
      if (reset || ((state_r == ST_LOOKUP) && clr_s)) begin
         reads_r  <= 32'd0;
         writes_r <= 32'd0;
         hits_r   <= 32'd0;
         misses_r <= 32'd0;
      end else if (state_r == ST_LOOKUP) begin
         reads_r  <= sat_inc(reads_r, inc_rd_s);
         writes_r <= sat_inc(writes_r, inc_wr_s);
         hits_r   <= sat_inc(hits_r, inc_hit_s);
         misses_r <= sat_inc(misses_r, inc_miss_s);
      end else begin
         reads_r  <= reads_r;
         writes_r <= writes_r;
         hits_r   <= hits_r;
         misses_r <= misses_r;
      end
   end

   assign wr_en       = wr_en_r;
   assign done        = done_r;
   assign hit         = hit_r;
   assign evict_wb    = evict_wb_r;
   assign array_clear = array_clear_r;
   assign bus_op      = bus_op_r;
   assign wr_line     = wr_line_r;
   assign reads       = reads_r;
   assign writes      = writes_r;
   assign hits        = hits_r;
   assign misses      = misses_r;
endmodule

// File: tb/tb_cache_line_controller.sv
// Bench for cache_line_controller: behavioural array model, command table
// pushed to a scoreboard queue, results popped and compared on done.
module tb_cache_line_controller;
   import cache_line_controller_pkg::*;

   logic        clk = 1'b0;
   logic        reset, cmd_valid, cmd_ready;
   command_t    cmd;
   logic [SI-1:0] set_index;
   cache_set_t  rd_line, wr_line;
   logic        wr_en, array_clear, done, hit, evict_wb;
   logic [2:0]  bus_op;
   logic [31:0] reads, writes, hits, misses;
   logic        tb_clear;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cache_line_controller dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd(cmd), .set_index(set_index), .rd_line(rd_line), .wr_en(wr_en),
      .wr_line(wr_line), .array_clear(array_clear), .done(done), .hit(hit),
      .bus_op(bus_op), .evict_wb(evict_wb), .reads(reads), .writes(writes),
      .hits(hits), .misses(misses)
   );

   typedef struct {
      logic [3:0]       op;
      logic [31:0]      addr;
      logic             e_hit;
      logic [2:0]       e_bus;
      logic             e_evict;
      logic             e_wr;
      logic             e_clr;
      int               way;     // -1: no per-way check
      logic [TAG_W-1:0] e_tag;
      mesi_t            e_mesi;
      logic [LW-1:0]    e_lru;
      logic             e_same;  // wr_line must equal the stored set
      logic [31:0]      e_rd, e_wrc, e_hits, e_miss;
   } vec_t;

   vec_t sb_q[$];
   vec_t vecs[$];
   vec_t e;

   // Array model: registered read, write on wr_en, reinit on clear.
   cache_set_t mem [SETS];

   function automatic cache_set_t empty_set();
      cache_set_t s;
      for (int w = 0; w < WAYS; w++) begin
         s[w].tag  = '0;
         s[w].mesi = MESI_I;
         s[w].lru  = LW'(w);
      end
      return s;
   endfunction

   always @(posedge clk) begin
      if (array_clear || tb_clear) begin
         for (int s = 0; s < SETS; s++) mem[s] <= empty_set();
      end else if (wr_en) begin
         mem[set_index] <= wr_line;
      end
      rd_line <= mem[set_index];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input int tag, input int set,
                               input logic h, input logic [2:0] bus, input logic ev,
                               input logic wr, input logic clr, input int way,
                               input int etag, input mesi_t em, input int elru,
                               input logic same, input logic [31:0] r, input logic [31:0] w,
                               input logic [31:0] hh, input logic [31:0] m);
      vec_t v;
      v.op = op;
      v.addr = {TAG_W'(tag), SI'(set), 6'h00};
      v.e_hit = h; v.e_bus = bus; v.e_evict = ev; v.e_wr = wr; v.e_clr = clr;
      v.way = way; v.e_tag = TAG_W'(etag); v.e_mesi = em; v.e_lru = LW'(elru);
      v.e_same = same; v.e_rd = r; v.e_wrc = w; v.e_hits = hh; v.e_miss = m;
      return v;
   endfunction

   // Scoreboard consumer: every done pops one expected record.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("hit", hit, e.e_hit);
            chk("bus_op", bus_op, e.e_bus);
            chk("evict_wb", evict_wb, e.e_evict);
            chk("wr_en", wr_en, e.e_wr);
            chk("array_clear", array_clear, e.e_clr);
            chk("reads", reads, e.e_rd);
            chk("writes", writes, e.e_wrc);
            chk("hits", hits, e.e_hits);
            chk("misses", misses, e.e_miss);
            if (e.way >= 0) begin
               chk("way_tag", wr_line[e.way].tag, e.e_tag);
               chk("way_mesi", wr_line[e.way].mesi, e.e_mesi);
               chk("way_lru", wr_line[e.way].lru, e.e_lru);
            end
            if (e.e_same) begin
               n_checks++;
               if (wr_line !== mem[set_index]) begin
                  n_errors++;
                  $display("FAIL wr_line_same: got %h expected %h", wr_line, mem[set_index]);
               end
            end
         end
      end
   end

   // Issue one command from a negedge, checking handshake timing and set hold.
   task automatic run(input vec_t v);
      int n;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd = {v.op, v.addr};
      sb_q.push_back(v);
      @(negedge clk);
      cmd = {4'd1, 32'hFFFF_FFC0};   // still valid while busy: must be ignored
      chk("ready_lookup", cmd_ready, 1'b0);
      chk("done_lookup", done, 1'b0);
      chk("set_lookup", set_index, v.addr[19:6]);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("done_update", done, 1'b1);
      chk("ready_update", cmd_ready, 1'b0);
      chk("set_update", set_index, v.addr[19:6]);
      @(negedge clk);
      chk("done_pulse", done, 1'b0);
      chk("ready_idle", cmd_ready, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // set 1 / tag 0 (address 0x40)
      vecs.push_back(mk(4'd0, 0, 1, 1'b0, BUS_READ, 1'b0, 1'b1, 1'b0, 0, 0, MESI_E, 0, 1'b0, 1, 0, 0, 1));
      vecs.push_back(mk(4'd0, 0, 1, 1'b1, BUS_NONE, 1'b0, 1'b1, 1'b0, 0, 0, MESI_E, 0, 1'b0, 2, 0, 1, 1));
      vecs.push_back(mk(4'd1, 0, 1, 1'b1, BUS_NONE, 1'b0, 1'b1, 1'b0, 0, 0, MESI_M, 0, 1'b0, 2, 1, 2, 1));
      vecs.push_back(mk(4'd4, 0, 1, 1'b1, BUS_WRITE, 1'b0, 1'b1, 1'b0, 0, 0, MESI_S, 0, 1'b0, 2, 1, 2, 1));
      vecs.push_back(mk(4'd3, 0, 1, 1'b1, BUS_NONE, 1'b0, 1'b1, 1'b0, 0, 0, MESI_I, 0, 1'b0, 2, 1, 2, 1));
      vecs.push_back(mk(4'd3, 7, 1, 1'b0, BUS_NONE, 1'b0, 1'b1, 1'b0, -1, 0, MESI_I, 0, 1'b1, 2, 1, 2, 1));
      // set 5: write miss, seven read misses, then a dirty eviction of way 0
      vecs.push_back(mk(4'd1, 1, 5, 1'b0, BUS_RFO, 1'b0, 1'b1, 1'b0, 0, 1, MESI_M, 0, 1'b0, 2, 2, 2, 2));
      for (int t = 2; t <= 8; t++)
         vecs.push_back(mk(4'd0, t, 5, 1'b0, BUS_READ, 1'b0, 1'b1, 1'b0, t - 1, t, MESI_E, 0, 1'b0,
                           32'(1 + t), 2, 2, 32'(1 + t)));
      vecs.push_back(mk(4'd0, 9, 5, 1'b0, BUS_READ, 1'b1, 1'b1, 1'b0, 0, 9, MESI_E, 0, 1'b0, 10, 2, 2, 10));
      vecs.push_back(mk(4'd0, 2, 5, 1'b1, BUS_NONE, 1'b0, 1'b1, 1'b0, 1, 2, MESI_E, 0, 1'b0, 11, 2, 3, 10));
      vecs.push_back(mk(4'd1, 3, 5, 1'b1, BUS_NONE, 1'b0, 1'b1, 1'b0, 2, 3, MESI_M, 0, 1'b0, 11, 3, 4, 10));
      vecs.push_back(mk(4'd4, 4, 5, 1'b1, BUS_NONE, 1'b0, 1'b1, 1'b0, 3, 4, MESI_S, 7, 1'b0, 11, 3, 4, 10));
      vecs.push_back(mk(4'd1, 4, 5, 1'b1, BUS_INVALIDATE, 1'b0, 1'b1, 1'b0, 3, 4, MESI_M, 0, 1'b0, 11, 4, 5, 10));
      // opcode 9, undefined 5, clear, then a miss on the cleared array
      vecs.push_back(mk(4'd9, 0, 1, 1'b0, BUS_NONE, 1'b0, 1'b0, 1'b0, -1, 0, MESI_I, 0, 1'b0, 11, 4, 5, 10));
      vecs.push_back(mk(4'd5, 0, 1, 1'b0, BUS_NONE, 1'b0, 1'b0, 1'b0, -1, 0, MESI_I, 0, 1'b0, 11, 4, 5, 10));
      vecs.push_back(mk(4'd8, 0, 1, 1'b0, BUS_NONE, 1'b0, 1'b0, 1'b1, -1, 0, MESI_I, 0, 1'b0, 0, 0, 0, 0));
      vecs.push_back(mk(4'd0, 0, 1, 1'b0, BUS_READ, 1'b0, 1'b1, 1'b0, 0, 0, MESI_E, 0, 1'b0, 1, 0, 0, 1));

      reset = 1'b1; tb_clear = 1'b1; cmd_valid = 1'b0; cmd = '0;
      repeat (3) @(negedge clk);
      tb_clear = 1'b0;
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_hit", hit, 1'b0);
      chk("rst_evict", evict_wb, 1'b0);
      chk("rst_clear", array_clear, 1'b0);
      chk("rst_bus", bus_op, 3'd0);
      chk("rst_set", set_index, '0);
      chk("rst_counters", {reads, writes, hits, misses}, '0);
      reset = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) run(vecs[i]);

      // Reset while a write sits in LOOKUP: nothing may complete.
      cmd_valid = 1'b1;
      cmd = {4'd1, TAG_W'(3), SI'(9), 6'h00};
      @(negedge clk);
      cmd_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_ready", cmd_ready, 1'b1);
      chk("rst_mid_reads", reads, 32'd0);
      chk("rst_mid_misses", misses, 32'd0);
      for (int c = 0; c < 3; c++) begin
         chk("rst_mid_wr_en", wr_en, 1'b0);
         chk("rst_mid_done", done, 1'b0);
         @(negedge clk);
      end

      // Saturated read counter must hold across a read hit.
      force dut.reads_r = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.reads_r;
      @(negedge clk);
      chk("sat_preload", reads, 32'hFFFF_FFFF);
      run(mk(4'd0, 0, 1, 1'b1, BUS_NONE, 1'b0, 1'b1, 1'b0, 0, 0, MESI_E, 0, 1'b0,
             32'hFFFF_FFFF, 0, 1, 0));

      repeat (2) @(negedge clk);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
